// File: rtl/ieeedrv_sd_arbiter.sv
// Round-robin arbiter that shares one MiSTer SD block-device channel among NREQ drive subunits.
// Define IEEEDRV_SDARB_TIMEOUT_EN to add a TMO_W-bit watchdog on the ISSUE phase (error pulse on expiry).
module ieeedrv_sd_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned TMO_W = 24
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_rd,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [32*NREQ-1:0] req_lba,
  input  logic [6*NREQ-1:0]  req_blk_cnt,
  input  logic [8*NREQ-1:0]  req_buff_din,
  output logic [NREQ-1:0]    req_done,
  output logic [NREQ-1:0]    req_err,
  output logic [NREQ-1:0]    req_buff_wr,
  output logic [31:0]        sd_lba,
  output logic [5:0]         sd_blk_cnt,
  output logic               sd_rd,
  output logic               sd_wr,
  input  logic               sd_ack,
  input  logic               sd_buff_wr,
  output logic [7:0]         sd_buff_din,
  output logic               busy
);
  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;
  state_t state, state_nxt;

  logic [GW-1:0]   ptr, grant, pick, cand;
  logic            any_req;
  logic            dir_wr;
  logic            tmo_hit;
  logic            err_flag;
  logic [NREQ-1:0] req_act;
  logic [31:0]     lba_arr [NREQ];
  logic [5:0]      cnt_arr [NREQ];
  logic [7:0]      din_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign lba_arr[g] = req_lba[32*g +: 32];
    assign cnt_arr[g] = req_blk_cnt[6*g +: 6];
    assign din_arr[g] = req_buff_din[8*g +: 8];
  end

  assign req_act = req_rd | req_wr;

  // Search starts one past the last served requester so every subunit gets a turn.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = GW'((32'(ptr) + k) % NREQ);
      if (!any_req && req_act[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   if (sd_ack) state_nxt = XFER;
               else if (tmo_hit) state_nxt = DONE;
      XFER:    if (!sd_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      grant      <= '0;
      sd_lba     <= '0;
      sd_blk_cnt <= '0;
      dir_wr     <= 1'b0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant      <= pick;
          sd_lba     <= lba_arr[pick];
          sd_blk_cnt <= cnt_arr[pick];
          dir_wr     <= !req_rd[pick];
        end
        ISSUE: begin
          sd_rd <= !(sd_ack || tmo_hit) && !dir_wr;
          sd_wr <= !(sd_ack || tmo_hit) && dir_wr;
        end
        DONE:    ptr <= grant;
        default: ;
      endcase
    end
  end

`ifdef IEEEDRV_SDARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (state == ISSUE) && (&tmo_cnt);

  // err_flag remembers why DONE was reached so the pulse goes out on req_err instead of req_done.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tmo_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (state == ISSUE) begin
      tmo_cnt  <= tmo_cnt + TMO_W'(1);
      err_flag <= tmo_hit && !sd_ack;
    end else begin
      tmo_cnt  <= '0;
    end
  end
`else
  if (TMO_W > 0) begin : g_no_tmo
    assign tmo_hit  = 1'b0;
    assign err_flag = 1'b0;
  end
`endif

  always_comb begin
    req_done    = '0;
    req_err     = '0;
    req_buff_wr = '0;
    sd_buff_din = '0;
    if (state == XFER) begin
      req_buff_wr[grant] = sd_buff_wr;
      sd_buff_din        = din_arr[grant];
    end
    if (state == DONE) begin
      if (err_flag) req_err[grant]  = 1'b1;
      else          req_done[grant] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ieeedrv_sd_arbiter.sv
// Self-checking bench for ieeedrv_sd_arbiter (NREQ=4): timeline model of each transaction,
// checked every cycle, plus directed literal checks of latency, fairness, routing and reset.
module tb_ieeedrv_sd_arbiter;
  localparam int unsigned N = 4;

  logic            clk_sys = 1'b0;
  logic            reset;
  logic [N-1:0]    req_rd, req_wr, req_done, req_err, req_buff_wr;
  logic [32*N-1:0] req_lba;
  logic [6*N-1:0]  req_blk_cnt;
  logic [8*N-1:0]  req_buff_din;
  logic [31:0]     sd_lba;
  logic [5:0]      sd_blk_cnt;
  logic            sd_rd, sd_wr, sd_ack, sd_buff_wr, busy;
  logic [7:0]      sd_buff_din;

  ieeedrv_sd_arbiter #(.NREQ(N), .TMO_W(24)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba), .req_blk_cnt(req_blk_cnt),
    .req_buff_din(req_buff_din), .req_done(req_done), .req_err(req_err),
    .req_buff_wr(req_buff_wr), .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Values the requesters currently present.
  logic [N-1:0] d_rd, d_wr;
  logic [31:0]  d_lba [N];
  logic [5:0]   d_cnt [N];
  logic [7:0]   d_din [N];

  // Expected DUT outputs for the current cycle.
  logic         e_busy, e_rd, e_wr;
  logic [31:0]  e_lba;
  logic [5:0]   e_cnt;
  logic [N-1:0] e_done, e_bwr;
  logic [7:0]   e_bdin;
  bit           check_en = 1'b0;
  int           mptr;

  // Observations used by the literal checks.
  int          done_log[$];
  logic [31:0] done_lba;
  int          req_cyc, rise_cyc;
  logic [31:0] rise_lba;
  logic [5:0]  rise_cnt;
  logic        prev_rd = 1'b0;
  int          bwr0 = 0, bwr1 = 0, a5 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_sys) begin
    if (check_en) begin
      chk("busy",        32'(busy),        32'(e_busy));
      chk("sd_rd",       32'(sd_rd),       32'(e_rd));
      chk("sd_wr",       32'(sd_wr),       32'(e_wr));
      chk("sd_lba",      sd_lba,           e_lba);
      chk("sd_blk_cnt",  32'(sd_blk_cnt),  32'(e_cnt));
      chk("req_done",    32'(req_done),    32'(e_done));
      chk("req_err",     32'(req_err),     32'd0);
      chk("req_buff_wr", 32'(req_buff_wr), 32'(e_bwr));
      chk("sd_buff_din", 32'(sd_buff_din), 32'(e_bdin));
    end
    for (int i = 0; i < N; i++)
      if (req_done[i] === 1'b1) begin
        done_log.push_back(i);
        done_lba = sd_lba;
      end
    if (sd_rd === 1'b1 && prev_rd !== 1'b1) begin
      rise_cyc = cyc;
      rise_lba = sd_lba;
      rise_cnt = sd_blk_cnt;
    end
    prev_rd = sd_rd;
    if (req_buff_wr[0] === 1'b1) begin
      bwr0++;
      if (sd_buff_din === 8'hA5) a5++;
    end
    if (req_buff_wr[1] === 1'b1) bwr1++;
  end

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic drive();
    req_rd = d_rd;
    req_wr = d_wr;
    for (int i = 0; i < N; i++) begin
      req_lba[32*i +: 32]     = d_lba[i];
      req_blk_cnt[6*i +: 6]   = d_cnt[i];
      req_buff_din[8*i +: 8]  = d_din[i];
    end
  endtask

  task automatic idle_exp();
    e_busy = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
    e_done = '0; e_bwr = '0; e_bdin = '0;
  endtask

  task automatic zero_exp();
    idle_exp();
    e_lba = '0;
    e_cnt = '0;
  endtask

  task automatic perturb(input int w, input bit scr);
    if (scr) begin
      for (int i = 0; i < N; i++) begin
        d_lba[i] = $urandom;
        d_cnt[i] = 6'($urandom);
        d_din[i] = 8'($urandom);
        if (i != w && $urandom_range(3, 0) == 0) begin
          d_rd[i] = 1'($urandom);
          d_wr[i] = 1'($urandom);
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    zero_exp();
    mptr = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One transaction starting in an idle cycle; the host acks ack_dly cycles after the request
  // appears and keeps ack high for xfer_len strobe cycles.
  task automatic txn(input int ack_dly, input int xfer_len, input bit scr, input bit rst_xfer,
                     input bit chg, input logic [31:0] chg_val, input bit full);
    int w, j;
    bit found, l_wr;
    logic [31:0] l_lba;
    logic [5:0]  l_cnt;
    drive();
    idle_exp();
    req_cyc = cyc;
    found = 1'b0;
    w = 0;
    for (int k = 1; k <= N; k++) begin
      j = (mptr + k) % N;
      if (!found && (d_rd[j] || d_wr[j])) begin
        found = 1'b1;
        w = j;
      end
    end
    tick();
    if (!found) return;
    l_lba = d_lba[w];
    l_cnt = d_cnt[w];
    l_wr  = !d_rd[w];
    perturb(w, scr);
    drive();
    e_busy = 1'b1; e_lba = l_lba; e_cnt = l_cnt;
    for (int k = 0; k < ack_dly; k++) begin
      tick();
      perturb(w, scr);
      if (chg && k == 0) d_lba[w] = chg_val;
      if (k == ack_dly - 1) sd_ack = 1'b1;
      drive();
      e_rd = !l_wr;
      e_wr = l_wr;
    end
    for (int k = 0; k <= xfer_len; k++) begin
      tick();
      perturb(w, scr);
      e_rd = 1'b0;
      e_wr = 1'b0;
      if (k == xfer_len) begin
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
      end else begin
        sd_buff_wr = full ? 1'b1 : 1'($urandom);
      end
      drive();
      e_bwr = '0;
      e_bwr[w] = sd_buff_wr;
      e_bdin = d_din[w];
      if (rst_xfer && k == 1) begin
        reset = 1'b1;
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        zero_exp();
        repeat (3) tick();
        reset = 1'b0;
        mptr = 0;
        return;
      end
    end
    tick();
    perturb(w, scr);
    d_rd[w] = 1'b0;
    d_wr[w] = 1'b0;
    drive();
    e_bwr = '0;
    e_bdin = '0;
    e_done = '0;
    e_done[w] = 1'b1;
    mptr = w;
    tick();
    e_done = '0;
    e_busy = 1'b0;
  endtask

  int order[5] = '{1, 2, 3, 0, 1};
  int r;

  initial begin
    reset = 1'b1;
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    d_rd = '0;
    d_wr = '0;
    for (int i = 0; i < N; i++) begin
      d_lba[i] = '0; d_cnt[i] = '0; d_din[i] = '0;
    end
    drive();
    zero_exp();
    mptr = 0;
    tick();
    tick();
    check_en = 1'b1;
    tick();
    reset = 1'b0;

    // Single read from requester 1.
    d_rd[1] = 1'b1; d_lba[1] = 32'h0000_0123; d_cnt[1] = 6'd3;
    txn(10, 4, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("rd_latency", 32'(rise_cyc - req_cyc), 32'd2);
    chk("rd_lba", rise_lba, 32'h123);
    chk("rd_cnt", 32'(rise_cnt), 32'd3);
    chk("rd_done_cnt", 32'(done_log.size()), 32'd1);
    if (done_log.size() > 0) chk("rd_done_who", 32'(done_log[0]), 32'd1);

    // Fairness with everyone asserting continuously.
    do_reset();
    done_log.delete();
    for (int t = 0; t < 5; t++) begin
      d_rd = '1;
      d_wr = '0;
      for (int i = 0; i < N; i++) d_lba[i] = $urandom;
      txn($urandom_range(3, 1), $urandom_range(4, 1), 1'b0, 1'b0, 1'b0, '0, 1'b0);
    end
    chk("rr_count", 32'(done_log.size()), 32'd5);
    for (int k = 0; k < 5 && k < done_log.size(); k++)
      chk("rr_order", 32'(done_log[k]), 32'(order[k]));

    // Grant 2, then reset in the middle of granting 3; the pointer must restart at 0.
    d_rd = '1;
    txn(2, 2, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    d_rd = '1;
    done_log.delete();
    txn(2, 4, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("rst_no_done", 32'(done_log.size()), 32'd0);
    txn(2, 2, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("post_rst_done_cnt", 32'(done_log.size()), 32'd1);
    if (done_log.size() > 0) chk("post_rst_grant", 32'(done_log[0]), 32'd1);

    // Buffer routing: requester 0 writes 512 strobes.
    d_rd = '0; d_wr = '0; d_wr[0] = 1'b1;
    d_din[0] = 8'hA5; d_din[1] = 8'h5A;
    bwr0 = 0; bwr1 = 0; a5 = 0;
    txn(2, 512, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("route_strobes0", 32'(bwr0), 32'd512);
    chk("route_din_a5", 32'(a5), 32'd512);
    chk("route_strobes1", 32'(bwr1), 32'd0);

    // Requester changes its LBA during ISSUE.
    d_rd = '0; d_wr = '0; d_rd[0] = 1'b1; d_lba[0] = 32'h10;
    txn(3, 2, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
    chk("lba_hold", done_lba, 32'h10);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(3, 0);
        d_rd[i]  = (r == 1 || r == 3);
        d_wr[i]  = (r >= 2);
        d_lba[i] = $urandom;
        d_cnt[i] = 6'($urandom);
        d_din[i] = 8'($urandom);
      end
      txn($urandom_range(4, 1), $urandom_range(6, 0), 1'b1, 1'b0, 1'b0, '0, 1'b0);
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ieeedrv_sd_arbiter.md
Name: ieeedrv_sd_arbiter

Overview:
- Shares one MiSTer SD block-device channel between NREQ drive subunits: drive mechanisms, two per drive, up to four drives.
- Each subunit presents a read or write request with LBA and block count. The arbiter grants subunits round-robin and forwards the request to the host channel.
- Routes buffer traffic only to the granted subunit, then returns a one-cycle completion pulse.
- Sits between the per-subunit sd_* outputs of the drive array and the single host sd_* channel in the top level.

Parameters:
- NREQ, 2, number of requesters (1..8)
- TMO_W, 24, width of the ack-watchdog counter (optional feature only)

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_rd  in  NREQ  per-requester read request level; held until its done pulse
- req_wr  in  NREQ  per-requester write request level; held until its done pulse
- req_lba  in  32*NREQ  per-requester LBA; slice i at [32i+31:32i]
- req_blk_cnt  in  6*NREQ  per-requester block count minus one
- req_buff_din  in  8*NREQ  per-requester write data for the host
- req_done  out  NREQ  one-cycle completion pulse to the granted requester
- req_err  out  NREQ  one-cycle error pulse; stays 0 unless the optional feature is compiled in
- req_buff_wr  out  NREQ  buffer write strobe, routed to the granted requester only
- sd_lba  out  32  host LBA
- sd_blk_cnt  out  6  host block count
- sd_rd  out  1  host read request
- sd_wr  out  1  host write request
- sd_ack  in  1  host acknowledge; high for the whole transfer
- sd_buff_wr  in  1  host buffer write strobe
- sd_buff_din  out  8  write data to the host, muxed from the granted requester
- busy  out  1  high from grant through done

Behaviour:
- Reset values: every output is 0, FSM is IDLE, round-robin pointer = 0, grant = 0.
- Reset mid-transfer aborts immediately. No done pulse is issued. Requesters re-present their requests after reset.
- FSM states: IDLE, ISSUE, XFER, DONE.
- IDLE:
  - Scan requests (req_rd|req_wr) from pointer+1 upward, wrapping modulo NREQ. First asserted requester wins.
  - Latch grant, LBA, block count and direction. If both rd and wr are set, rd wins.
  - Go to ISSUE the next cycle. Latency from request to sd_rd/sd_wr is 2 clocks.
- ISSUE:
  - Drive sd_rd or sd_wr = 1 with the latched lba and blk_cnt.
  - On sd_ack=1, drop sd_rd/sd_wr in the same registered update and go to XFER.
- XFER:
  - req_buff_wr[grant] = sd_buff_wr, combinational.
  - sd_buff_din = req_buff_din[grant], combinational.
  - On sd_ack=0, go to DONE.
- DONE:
  - req_done[grant] = 1 for exactly one cycle.
  - Pointer = grant. Return to IDLE.
  - The requester drops its request on seeing done. A request still high at the next IDLE scan is treated as a new request.
- Outside XFER, all req_buff_wr are 0 and sd_buff_din = 0.
- Latched lba, blk_cnt and direction stay stable from ISSUE until DONE, even if the requester changes its inputs.
- If a requester deasserts before being granted, it is simply skipped. Once granted, the transfer always completes.
- Fairness: with all requesters asserting continuously, the grant order is 1,2,...,NREQ-1,0,1,...
- NREQ=1 degenerates to a fixed grant; the pointer stays 0.

Optional Feature:
- Macro IEEEDRV_SDARB_TIMEOUT_EN.
- With the macro defined:
  - A TMO_W-bit counter clears on entering ISSUE and increments every cycle in ISSUE.
  - On all-ones, drop sd_rd/sd_wr and pulse req_err[grant] (no req_done).
  - Pointer = grant, FSM returns to IDLE.
  - XFER is not watched.
- Without the macro: no counter, req_err tied 0, ISSUE waits indefinitely.

Test Plan:
- Single read, NREQ=2: req_rd[1]=1, lba1=0x00000123, cnt1=3, ack high 10 clocks after sd_rd.
  - Expect sd_rd 2 clocks after the request, sd_lba=0x123, sd_blk_cnt=3.
  - sd_rd falls the clock after ack; req_done[1] pulses once, 1 clock after ack falls.
- Round-robin: all four requesters assert continuously, NREQ=4, after reset.
  - Grant order 1,2,3,0,1; each done pulse goes only to the granted bit.
- Buffer routing: requester 0 writes, req_buff_din0=0xA5, req_buff_din1=0x5A, 512 sd_buff_wr strobes.
  - sd_buff_din=0xA5 throughout.
  - req_buff_wr[0] mirrors sd_buff_wr; req_buff_wr[1] stays 0.
- Input change during transfer: lba0 changes from 0x10 to 0x20 while in ISSUE.
  - sd_lba stays 0x10 until DONE.
- Reset mid-transfer: assert reset during XFER.
  - All outputs 0 asynchronously; no req_done.
  - The next grant after release starts from requester 1.
- Timeout (macro defined, TMO_W=4): req_wr[0]=1, ack never asserted.
  - sd_wr drops after 15 ISSUE cycles; req_err[0] pulses once; busy=0 the following cycle.
